// File: rtl/rng_share_arb.sv
// rng_share_arb: shares one 16-bit Fibonacci LFSR round-robin among NREQ requesters, one word per cycle.
// Latency: grant and word are registered one cycle after the request; back-to-back grants every cycle.
// Backpressure: none; requests are levels, losers keep req_i high, a seed load drops the pending request.
// Optional: define RNG_ARB_STATS_EN to add gnt_cnt_o, one saturating 16-bit grant counter per requester.
module rng_share_arb #(
  parameter int          NREQ   = 4,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          WARMUP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       seed_i,
  input  logic              seed_load_i,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [15:0]       rnd_o,
  output logic              busy_o
`ifdef RNG_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] gnt_cnt_o
`endif
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {ST_WARMUP, ST_SERVE} state_t;
  // With no warm-up configured the block comes out of reset (and reseed) ready to serve.
  localparam state_t ST_START = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_lfsr, w_lfsr_nxt, w_step;
  logic [7:0]      r_wcnt, w_wcnt_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt, w_win;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt, w_hi;
  logic [15:0]     r_rnd, w_rnd_nxt;

  // Taps 0,2,3,5 shifted in at the top; a nonzero state can never reach zero.
  assign w_step = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Round-robin pick: lowest request at or above the pointer, else wrap to the lowest request overall.
  always_comb begin
    w_hi  = '0;
    w_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_hi[i] = req_i[i] && (i >= int'(r_ptr));
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) w_win = PW'(i);
    end
    if (|w_hi) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (w_hi[i]) w_win = PW'(i);
      end
    end
  end

  // Next-state: seed load overrides everything, warm-up burns steps, serve hands out pre-step words.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_wcnt_nxt  = r_wcnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_rnd_nxt   = r_rnd;
    if (seed_load_i) begin
      w_lfsr_nxt  = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
      w_wcnt_nxt  = '0;
      w_state_nxt = ST_START;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          w_lfsr_nxt = w_step;
          w_wcnt_nxt = r_wcnt + 8'd1;
          if (r_wcnt == 8'(WARMUP - 1)) w_state_nxt = ST_SERVE;
        end
        ST_SERVE: begin
          if (|req_i) begin
            w_gnt_nxt  = NREQ'(1) << w_win;
            w_rnd_nxt  = r_lfsr;
            w_lfsr_nxt = w_step;
            w_ptr_nxt  = (int'(w_win) == NREQ - 1) ? '0 : w_win + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; async reset leaves no partial grant behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_START;
      r_lfsr  <= SEED;
      r_wcnt  <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_rnd   <= w_rnd_nxt;
    end
  end

  assign gnt_o  = r_gnt;
  assign rnd_o  = r_rnd;
  assign busy_o = (r_state == ST_WARMUP);

`ifdef RNG_ARB_STATS_EN
  logic [NREQ-1:0][15:0] r_cnt;

  // Per-requester grant counters; only rst_n clears them, they stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_gnt[i] && (r_cnt[i] != 16'hFFFF)) r_cnt[i] <= r_cnt[i] + 16'd1;
      end
    end
  end

  assign gnt_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_rng_share_arb.sv
// tb_rng_share_arb: directed and randomized stimulus against a queue-based reference model.
// Driver pushes the expected grant/word/busy for every cycle; a monitor pops and compares after each edge.
// Directed sections cover warm-up, round-robin order, zero-seed reseed, reseed mid-warm-up and async reset.
module tb_rng_share_arb;
  localparam int          NREQ   = 4;
  localparam logic [15:0] SEED   = 16'h0001;
  localparam int          WARMUP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            seed_load_i = 1'b0;
  logic [15:0]     seed_i = '0;
  logic [NREQ-1:0] req_i = '0;
  logic [NREQ-1:0] gnt_o;
  logic [15:0]     rnd_o;
  logic            busy_o;
`ifdef RNG_ARB_STATS_EN
  logic [NREQ*16-1:0] gnt_cnt_o;
  int unsigned        m_cnt[NREQ];
`endif

  always #5 clk = ~clk;

  rng_share_arb #(.NREQ(NREQ), .SEED(SEED), .WARMUP(WARMUP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_i      (seed_i),
    .seed_load_i (seed_load_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .rnd_o       (rnd_o),
    .busy_o      (busy_o)
`ifdef RNG_ARB_STATS_EN
    ,
    .gnt_cnt_o   (gnt_cnt_o)
`endif
  );

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [15:0]     rnd;
    logic            busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: abstract view of the source (current word, serving flag, warm-up count, pointer).
  logic [15:0] m_s, m_rnd;
  bit          m_serve;
  int          m_wcnt, m_ptr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s     = SEED;
    m_rnd   = '0;
    m_serve = (WARMUP == 0);
    m_wcnt  = 0;
    m_ptr   = 0;
    sb_q.delete();
`ifdef RNG_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
`endif
  endtask

  // Apply inputs for the coming edge and predict what the DUT shows after it.
  task automatic drive(input logic [NREQ-1:0] req, input logic sl, input logic [15:0] sd);
    exp_t e;
    int   w;
    req_i       = req;
    seed_load_i = sl;
    seed_i      = sd;
    e.gnt       = '0;
    if (sl) begin
      m_s     = (sd == 16'h0) ? 16'h0001 : sd;
      m_wcnt  = 0;
      m_serve = (WARMUP == 0);
    end else if (!m_serve) begin
      m_s = lfsr_next(m_s);
      m_wcnt++;
      if (m_wcnt >= WARMUP) m_serve = 1'b1;
    end else if (req != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      e.gnt[w] = 1'b1;
      m_rnd    = m_s;
      m_s      = lfsr_next(m_s);
      m_ptr    = (w + 1) % NREQ;
`ifdef RNG_ARB_STATS_EN
      if (m_cnt[w] < 32'hFFFF) m_cnt[w]++;
`endif
    end
    e.rnd  = m_rnd;
    e.busy = !m_serve;
    sb_q.push_back(e);
  endtask

  // One full cycle: drive on the falling edge, return just after the rising edge.
  task automatic cyc(input logic [NREQ-1:0] req, input logic sl, input logic [15:0] sd);
    @(negedge clk);
    drive(req, sl, sd);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every post-edge output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_gnt", 32'(gnt_o), 32'(e.gnt));
          chk("sb_rnd", 32'(rnd_o), 32'(e.rnd));
          chk("sb_busy", 32'(busy_o), 32'(e.busy));
        end else if (gnt_o != '0) begin
          chk("unexpected_gnt", 32'(gnt_o), 32'h0);
        end
        chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'h1);
      end
    end
  end

  initial begin
    logic [NREQ-1:0] eg1[5];
    logic [15:0]     er1[5];
    logic [NREQ-1:0] eg2[4];
    eg1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    er1 = '{16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100};
    eg2 = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_gnt", 32'(gnt_o), 32'h0);
    chk("reset_rnd", 32'(rnd_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h1);

    // Warm-up: four busy cycles, requests ignored.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    chk("warm_busy0", 32'(busy_o), 32'h1);
    for (int i = 1; i < 4; i++) begin
      cyc(4'b1111, 1'b0, 16'h0);
      chk("warm_busy", 32'(busy_o), (i == 3) ? 32'h0 : 32'h1);
      chk("warm_nognt", 32'(gnt_o), 32'h0);
    end

    // All requesting: rotate through every requester, words walk down from 16'h1000.
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 1'b0, 16'h0);
      chk("rr_all_gnt", 32'(gnt_o), 32'(eg1[i]));
      chk("rr_all_rnd", 32'(rnd_o), 32'(er1[i]));
    end

    // Sparse requests from pointer 1.
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0101, 1'b0, 16'h0);
      chk("rr_0101_gnt", 32'(gnt_o), 32'(eg2[i]));
    end

    // Zero seed with a pending request: request dropped, warm-up restarts from 16'h0001.
    cyc(4'b0010, 1'b1, 16'h0000);
    chk("reseed_nognt", 32'(gnt_o), 32'h0);
    chk("reseed_busy", 32'(busy_o), 32'h1);
    for (int i = 0; i < 4; i++) cyc(4'b1111, 1'b0, 16'h0);
    chk("reseed_done", 32'(busy_o), 32'h0);
    cyc(4'b1111, 1'b0, 16'h0);
    chk("reseed_first_rnd", 32'(rnd_o), 32'h1000);

    // Reseed at wcnt=2: four more busy cycles counted from the reload.
    cyc(4'b0000, 1'b1, 16'h1234);
    cyc(4'b1111, 1'b0, 16'h0);
    cyc(4'b1111, 1'b0, 16'h0);
    cyc(4'b1111, 1'b1, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1111, 1'b0, 16'h0);
      chk("rewarm_busy", 32'(busy_o), (i == 3) ? 32'h0 : 32'h1);
    end

    // Randomized traffic with occasional reseeds, some of them zero.
    for (int i = 0; i < 1500; i++) begin
      logic            sl;
      logic [15:0]     sd;
      logic [NREQ-1:0] rq;
      rq = NREQ'($urandom);
      sl = ($urandom_range(0, 49) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc(rq, sl, sd);
    end

    // Settle into SERVE, then assert reset while a grant is on the outputs.
    for (int i = 0; i < 6; i++) cyc(4'b0000, 1'b0, 16'h0);
`ifdef RNG_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("stats_cnt", 32'(gnt_cnt_o[16*i +: 16]), m_cnt[i]);
`endif
    cyc(4'b0100, 1'b0, 16'h0);
    chk("pre_reset_gnt", 32'(gnt_o), 32'h4);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_gnt", 32'(gnt_o), 32'h0);
    chk("async_reset_rnd", 32'(rnd_o), 32'h0);
    chk("async_reset_busy", 32'(busy_o), 32'h1);
`ifdef RNG_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("stats_reset", 32'(gnt_cnt_o[16*i +: 16]), 32'h0);
`endif

    // Restart after reset and serve a few words again.
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1010, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) cyc(4'b1010, 1'b0, 16'h0);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
